// File: rtl/mem_responder.sv
// Terminal slave for the mem_intf request protocol: executes masked writes and
// read-first reads against a word array, returning ordered responses through a 3-deep FIFO.
module mem_responder #(
    parameter logic [31:0] CLOCK_INFO    = 32'b0,
    parameter bit          WRITE_RESPOND = 1'b1,
    parameter int          ADDR_WIDTH    = 8,
    parameter int          DATA_WIDTH    = 32,
    parameter int          MASK_WIDTH    = 4,
    parameter int          ID_WIDTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  mem_in_valid,
    output logic                  mem_in_ready,
    input  logic                  mem_in_read_enable,
    input  logic [MASK_WIDTH-1:0] mem_in_write_enable,
    input  logic [ADDR_WIDTH-1:0] mem_in_addr,
    input  logic [DATA_WIDTH-1:0] mem_in_data,
    input  logic [ID_WIDTH-1:0]   mem_in_id,

    output logic                  mem_out_valid,
    input  logic                  mem_out_ready,
    output logic                  mem_out_read_enable,
    output logic [MASK_WIDTH-1:0] mem_out_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_out_addr,
    output logic [DATA_WIDTH-1:0] mem_out_data,
    output logic [ID_WIDTH-1:0]   mem_out_id
);

    localparam int LANE       = DATA_WIDTH / MASK_WIDTH;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int FIFO_DEPTH = 3;

    generate
        if (DATA_WIDTH % MASK_WIDTH != 0) begin : g_bad_mask_width
            $error("mem_responder: DATA_WIDTH must be a multiple of MASK_WIDTH");
        end
    endgenerate

    // Timing annotation only; folded into an intentionally unused net.
    logic unused_clock_info;
    assign unused_clock_info = ^CLOCK_INFO;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(FIFO_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // ------------------------------------------------------------------
    // Accept / ready
    // ------------------------------------------------------------------
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_re_q, s1_re_d;
    logic [MASK_WIDTH-1:0] s1_we_q, s1_we_d;
    logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;
    logic [ID_WIDTH-1:0]   s1_id_q, s1_id_d;
    logic [DATA_WIDTH-1:0] s1_data;

    logic [1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0] fifo_count_q, fifo_count_d;

    logic       accept;
    logic       responsive;
    logic       load_s1;
    logic       push;
    logic       pop;
    logic [2:0] occupancy;

    // Ready depends only on registered occupancy, never on mem_out_ready.
    assign occupancy    = {2'b00, s1_valid_q} + {1'b0, fifo_count_q};
    assign mem_in_ready = !rst && (occupancy < 3'(FIFO_DEPTH));
    assign accept       = mem_in_valid && mem_in_ready;
    assign responsive   = mem_in_read_enable || (WRITE_RESPOND && (|mem_in_write_enable));
    assign load_s1      = accept && responsive;

    // ------------------------------------------------------------------
    // Word array, split per write lane so each lane is a simple RAM with
    // a registered read-first port.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < MASK_WIDTH; gi++) begin : g_lane
            logic [LANE-1:0] lane_mem [DEPTH] = '{default: '0};
            logic [LANE-1:0] lane_rd_q;

            always_ff @(posedge clk) begin
                if (accept && mem_in_write_enable[gi]) begin
                    lane_mem[mem_in_addr] <= mem_in_data[gi*LANE +: LANE];
                end
                if (load_s1) begin
                    lane_rd_q <= lane_mem[mem_in_addr];
                end
            end

            assign s1_data[gi*LANE +: LANE] = lane_rd_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // s1: one-entry register holding the request echo alongside the read
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = load_s1;
        s1_re_d    = s1_re_q;
        s1_we_d    = s1_we_q;
        s1_addr_d  = s1_addr_q;
        s1_id_d    = s1_id_q;
        if (load_s1) begin
            s1_re_d   = mem_in_read_enable;
            s1_we_d   = mem_in_write_enable;
            s1_addr_d = mem_in_addr;
            s1_id_d   = mem_in_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
        end
        s1_re_q   <= s1_re_d;
        s1_we_q   <= s1_we_d;
        s1_addr_q <= s1_addr_d;
        s1_id_q   <= s1_id_d;
    end

    // ------------------------------------------------------------------
    // Response FIFO
    // ------------------------------------------------------------------
    logic                  fifo_re_q   [FIFO_DEPTH];
    logic [MASK_WIDTH-1:0] fifo_we_q   [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id_q   [FIFO_DEPTH];

    // s1 always drains the following edge; ready already reserved its slot.
    assign push = s1_valid_q;
    assign pop  = mem_out_valid && mem_out_ready;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_count_d = fifo_count_q;
        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + 2'd1;
            2'b01:   fifo_count_d = fifo_count_q - 2'd1;
            default: fifo_count_d = fifo_count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= 2'd0;
            rd_ptr_q     <= 2'd0;
            fifo_count_q <= 2'd0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_count_q <= fifo_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_re_q[wr_ptr_q]   <= s1_re_q;
            fifo_we_q[wr_ptr_q]   <= s1_we_q;
            fifo_addr_q[wr_ptr_q] <= s1_addr_q;
            fifo_data_q[wr_ptr_q] <= s1_data;
            fifo_id_q[wr_ptr_q]   <= s1_id_q;
        end
    end

    // Fields are forced to zero while empty so nothing stale shows after reset.
    assign mem_out_valid        = (fifo_count_q != 2'd0);
    assign mem_out_read_enable  = mem_out_valid ? fifo_re_q[rd_ptr_q]   : 1'b0;
    assign mem_out_write_enable = mem_out_valid ? fifo_we_q[rd_ptr_q]   : '0;
    assign mem_out_addr         = mem_out_valid ? fifo_addr_q[rd_ptr_q] : '0;
    assign mem_out_data         = mem_out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign mem_out_id           = mem_out_valid ? fifo_id_q[rd_ptr_q]   : '0;

endmodule
